// File: rtl/fall_pkg.sv
// fall_pkg: shared types and defaults for the falling-piece controller.
//   fall_state_t      - controller state encoding
//   DEF_*             - default parameter values
//   LINES_W, LEVEL_W  - widths of lines_total and level
//   LOCK_CNT_W        - width of the lock-delay counter
//   in_level_width()  - width of the in-level line counter for a given lines-per-level
package fall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPAWN  = 3'd1,
    ST_FALL   = 3'd2,
    ST_MOVE   = 3'd3,
    ST_GROUND = 3'd4,
    ST_LOCK   = 3'd5,
    ST_OVER   = 3'd6
  } fall_state_t;

  localparam int DEF_LOCK_DELAY      = 25000000;
  localparam int DEF_LINES_PER_LEVEL = 10;
  localparam int DEF_MAX_LEVEL       = 7;
  localparam int LINES_W             = 16;
  localparam int LEVEL_W             = 3;
  localparam int LOCK_CNT_W          = 26;

  // The counter only ever holds values below lines_per_level (at most 16).
  function automatic int in_level_width(input int lines_per_level);
    return (lines_per_level > 8) ? 4 : 3;
  endfunction

endpackage

// File: rtl/level_tracker.sv
// level_tracker: line accounting for one game.
//   CLK, RESET    - clock, synchronous active-high reset
//   clear         - start of a new game; zeroes all counts
//   clear_done    - accepted merge/clear result (qualifies clear_lines)
//   clear_lines   - rows cleared by the last lock, 0..4
//   level         - current level, saturating at MAX_LEVEL
//   lines_total   - cumulative cleared lines, saturating at all-ones
module level_tracker
  import fall_pkg::*;
#(
  parameter int LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               clear,
  input  logic               clear_done,
  input  logic [2:0]         clear_lines,
  output logic [LEVEL_W-1:0] level,
  output logic [LINES_W-1:0] lines_total
);

  localparam int CNT_W = in_level_width(LINES_PER_LEVEL);
  localparam logic [CNT_W:0]       LPL     = (CNT_W + 1)'(LINES_PER_LEVEL);
  localparam logic [LEVEL_W-1:0]   MAX_LVL = LEVEL_W'(MAX_LEVEL);

  logic [CNT_W-1:0] in_level_cnt;
  logic [CNT_W:0]   sum;
  logic [LINES_W:0] total_sum;

  // One extra bit on each sum catches the level wrap and the total overflow.
  assign sum       = {1'b0, in_level_cnt} + {{(CNT_W - 2){1'b0}}, clear_lines};
  assign total_sum = {1'b0, lines_total} + {{(LINES_W - 2){1'b0}}, clear_lines};

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      in_level_cnt <= '0;
      level        <= '0;
      lines_total  <= '0;
    end else if (clear_done) begin
      if (sum >= LPL) begin
        in_level_cnt <= CNT_W'(sum - LPL);
        if (level < MAX_LVL) level <= level + 1'b1;
      end else begin
        in_level_cnt <= sum[CNT_W-1:0];
      end
      lines_total <= total_sum[LINES_W] ? '1 : total_sum[LINES_W-1:0];
    end
  end

endmodule

// File: rtl/fall_controller.sv
// fall_controller: sequences each falling piece (spawn, gravity, lock delay,
// lock, line accounting) and drives the level-speed divider.
//   CLK, RESET                          - clock, synchronous active-high reset
//   start                               - begin a game from IDLE or OVER
//   tick                                - gravity pulse from the divider
//   soft_btn, hard_btn                  - soft-drop level, hard-drop pulse
//   spawn_req/spawn_done/spawn_blocked  - spawn handshake with the board
//   down_req/down_done/down_blocked     - one-row move handshake
//   lock_req/clear_done/clear_lines     - merge-and-clear handshake
//   drop, hard_drop, level              - speed selects and level to the divider
//   lines_total                         - cumulative cleared lines
//   game_over                           - high while in OVER
//
// state  | meaning
// IDLE   | no game yet; wait for start
// SPAWN  | spawn_req held until the board places a piece
// FALL   | piece airborne; wait for a gravity tick
// MOVE   | down_req held until the board evaluates the move
// GROUND | piece resting; lock counter running, tick retries the move
// LOCK   | lock_req held until merge and line clear finish
// OVER   | spawn blocked; game_over high, wait for start
module fall_controller
  import fall_pkg::*;
#(
  parameter int LOCK_DELAY      = DEF_LOCK_DELAY,
  parameter int LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               tick,
  input  logic               soft_btn,
  input  logic               hard_btn,
  output logic               spawn_req,
  input  logic               spawn_done,
  input  logic               spawn_blocked,
  output logic               down_req,
  input  logic               down_done,
  input  logic               down_blocked,
  output logic               lock_req,
  input  logic               clear_done,
  input  logic [2:0]         clear_lines,
  output logic               drop,
  output logic               hard_drop,
  output logic [LEVEL_W-1:0] level,
  output logic [LINES_W-1:0] lines_total,
  output logic               game_over
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_DELAY - 1);

  fall_state_t           state, state_nxt;
  logic                  hard_flag, hard_flag_nxt;
  logic                  from_ground, from_ground_nxt;
  logic                  soft_q;
  logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic                  in_play, hard_now, game_clear, clear_accept;

  assign in_play  = (state == ST_FALL) || (state == ST_MOVE) || (state == ST_GROUND);
  assign hard_now = hard_btn & in_play;

  always_comb begin
    state_nxt       = state;
    hard_flag_nxt   = hard_flag | hard_now;
    from_ground_nxt = from_ground;
    lock_cnt_nxt    = lock_cnt;
    game_clear      = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_nxt  = ST_SPAWN;
          game_clear = 1'b1;
        end
      end
      ST_SPAWN: begin
        hard_flag_nxt = 1'b0;
        if (spawn_done) state_nxt = spawn_blocked ? ST_OVER : ST_FALL;
      end
      ST_FALL: begin
        if (tick) begin
          state_nxt       = ST_MOVE;
          from_ground_nxt = 1'b0;
        end
      end
      ST_MOVE: begin
        if (down_done) begin
          if (!down_blocked) begin
            state_nxt = ST_FALL;
          end else if (hard_flag || hard_now) begin
            state_nxt = ST_LOCK;
          end else begin
            state_nxt = ST_GROUND;
            // A retry from GROUND keeps the time already spent resting.
            if (!from_ground) lock_cnt_nxt = '0;
          end
        end
      end
      ST_GROUND: begin
        lock_cnt_nxt = lock_cnt + 1'b1;
        if (hard_now || (lock_cnt == LOCK_LAST)) begin
          state_nxt = ST_LOCK;
        end else if (tick) begin
          state_nxt       = ST_MOVE;
          from_ground_nxt = 1'b1;
        end
      end
      ST_LOCK: begin
        if (clear_done) state_nxt = ST_SPAWN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      hard_flag   <= 1'b0;
      from_ground <= 1'b0;
      soft_q      <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      hard_flag   <= hard_flag_nxt;
      from_ground <= from_ground_nxt;
      soft_q      <= soft_btn;
      lock_cnt    <= lock_cnt_nxt;
    end
  end

  // Only a clear result that answers an outstanding lock_req is counted.
  assign clear_accept = clear_done & (state == ST_LOCK);

  level_tracker #(
    .LINES_PER_LEVEL (LINES_PER_LEVEL),
    .MAX_LEVEL       (MAX_LEVEL)
  ) u_level_tracker (
    .CLK         (CLK),
    .RESET       (RESET),
    .clear       (game_clear),
    .clear_done  (clear_accept),
    .clear_lines (clear_lines),
    .level       (level),
    .lines_total (lines_total)
  );

  // soft_btn is registered so drop has no combinational path from an input.
  assign spawn_req = (state == ST_SPAWN);
  assign down_req  = (state == ST_MOVE);
  assign lock_req  = (state == ST_LOCK);
  assign game_over = (state == ST_OVER);
  assign hard_drop = hard_flag;
  assign drop      = soft_q & ~hard_flag & ((state == ST_FALL) || (state == ST_MOVE));

endmodule

// File: tb/tb_fall_controller.sv
module tb_fall_controller;

  localparam int LD   = 20;
  localparam int LPL  = 10;
  localparam int MAXL = 7;

  logic       CLK, RESET;
  logic       start, tick, soft_btn, hard_btn;
  logic       spawn_req, spawn_done, spawn_blocked;
  logic       down_req, down_done, down_blocked;
  logic       lock_req, clear_done;
  logic [2:0] clear_lines;
  logic       drop, hard_drop, game_over;
  logic [2:0] level;
  logic [15:0] lines_total;

  fall_controller #(.LOCK_DELAY(LD), .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAXL)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .tick(tick), .soft_btn(soft_btn),
    .hard_btn(hard_btn), .spawn_req(spawn_req), .spawn_done(spawn_done),
    .spawn_blocked(spawn_blocked), .down_req(down_req), .down_done(down_done),
    .down_blocked(down_blocked), .lock_req(lock_req), .clear_done(clear_done),
    .clear_lines(clear_lines), .drop(drop), .hard_drop(hard_drop), .level(level),
    .lines_total(lines_total), .game_over(game_over)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game phase, remaining rest cycles, lines this game.
  localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_MOVE = 3,
                 P_GROUND = 4, P_LOCK = 5, P_OVER = 6;
  int   m_ph = P_IDLE;
  int   m_rem = 0;
  int   m_lines = 0;
  bit   m_hard = 0, m_soft = 0, m_retry = 0;
  int   m_nxt;
  bit   m_hn;
  bit   cmp_on = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_ph = P_IDLE; m_rem = 0; m_lines = 0; m_hard = 0; m_soft = 0; m_retry = 0;
    end else begin
      m_hn  = hard_btn && (m_ph == P_FALL || m_ph == P_MOVE || m_ph == P_GROUND);
      m_nxt = m_ph;
      case (m_ph)
        P_IDLE, P_OVER: if (start) begin m_nxt = P_SPAWN; m_lines = 0; end
        P_SPAWN: if (spawn_done) m_nxt = spawn_blocked ? P_OVER : P_FALL;
        P_FALL:  if (tick) begin m_nxt = P_MOVE; m_retry = 0; end
        P_MOVE: if (down_done) begin
          if (!down_blocked) m_nxt = P_FALL;
          else if (m_hard || m_hn) m_nxt = P_LOCK;
          else begin
            m_nxt = P_GROUND;
            if (!m_retry) m_rem = LD;
          end
        end
        P_GROUND: begin
          if (m_hn || m_rem == 1) m_nxt = P_LOCK;
          else begin
            m_rem = m_rem - 1;
            if (tick) begin m_nxt = P_MOVE; m_retry = 1; end
          end
        end
        P_LOCK: if (clear_done) begin m_lines = m_lines + int'(clear_lines); m_nxt = P_SPAWN; end
        default: m_nxt = P_IDLE;
      endcase
      if (m_hn) m_hard = 1;
      if (m_ph == P_SPAWN) m_hard = 0;
      m_soft = soft_btn;
      m_ph   = m_nxt;
    end
  end

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("spawn_req", int'(spawn_req), int'(m_ph == P_SPAWN));
      chk("down_req",  int'(down_req),  int'(m_ph == P_MOVE));
      chk("lock_req",  int'(lock_req),  int'(m_ph == P_LOCK));
      chk("game_over", int'(game_over), int'(m_ph == P_OVER));
      chk("hard_drop", int'(hard_drop), int'(m_hard));
      chk("drop", int'(drop), int'(m_soft && !m_hard && (m_ph == P_FALL || m_ph == P_MOVE)));
      chk("level", int'(level), (m_lines / LPL > MAXL) ? MAXL : m_lines / LPL);
      chk("lines_total", int'(lines_total), (m_lines > 65535) ? 65535 : m_lines);
    end
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic do_spawn(input logic b);
    spawn_done = 1; spawn_blocked = b; cyc(); spawn_done = 0; spawn_blocked = 0;
  endtask

  task automatic do_move(input logic b);
    tick = 1; cyc(); tick = 0;
    down_done = 1; down_blocked = b; cyc(); down_done = 0; down_blocked = 0;
  endtask

  task automatic do_lock(input int n);
    clear_done = 1; clear_lines = 3'(n); cyc(); clear_done = 0; clear_lines = 0;
  endtask

  task automatic pulse_hard();
    hard_btn = 1; cyc(); hard_btn = 0;
  endtask

  // From FALL: hard drop, land, clear n lines, spawn again.
  task automatic hard_piece(input int n);
    pulse_hard(); do_move(1); do_lock(n); do_spawn(0);
  endtask

  initial begin
    RESET = 1; start = 0; tick = 0; soft_btn = 0; hard_btn = 0;
    spawn_done = 0; spawn_blocked = 0; down_done = 0; down_blocked = 0;
    clear_done = 0; clear_lines = 0;
    repeat (3) cyc();
    cmp_on = 1;
    chk("reset spawn_req", int'(spawn_req), 0);
    chk("reset level", int'(level), 0);
    chk("reset lines_total", int'(lines_total), 0);
    chk("reset game_over", int'(game_over), 0);
    RESET = 0;

    // start, spawn, one free move
    start = 1; cyc(); start = 0;
    chk("spawn_req after start", int'(spawn_req), 1);
    do_spawn(0);
    chk("spawn_req dropped", int'(spawn_req), 0);
    tick = 1; cyc(); tick = 0;
    chk("down_req after tick", int'(down_req), 1);
    down_done = 1; cyc(); down_done = 0;
    chk("down_req dropped", int'(down_req), 0);
    chk("drop without soft", int'(drop), 0);

    // land and rest for the full lock delay
    do_move(1);
    chk("lock_req at ground entry", int'(lock_req), 0);
    repeat (LD - 1) cyc();
    chk("lock_req one cycle early", int'(lock_req), 0);
    cyc();
    chk("lock_req after lock delay", int'(lock_req), 1);
    do_lock(0);
    chk("spawn after zero clear", int'(spawn_req), 1);
    chk("lines after zero clear", int'(lines_total), 0);

    // soft then hard drop
    do_spawn(0);
    soft_btn = 1; cyc();
    chk("drop with soft", int'(drop), 1);
    pulse_hard();
    chk("hard_drop set", int'(hard_drop), 1);
    chk("drop masked by hard", int'(drop), 0);
    soft_btn = 0;
    repeat (3) do_move(0);
    chk("hard_drop held", int'(hard_drop), 1);
    do_move(1);
    chk("hard lock immediate", int'(lock_req), 1);
    do_lock(4);
    do_spawn(0);
    chk("hard_drop cleared by spawn", int'(hard_drop), 0);
    chk("level after 4", int'(level), 0);

    hard_piece(4);
    chk("level after 8", int'(level), 0);
    chk("lines after 8", int'(lines_total), 8);
    hard_piece(3);
    chk("level after 11", int'(level), 1);
    chk("lines after 11", int'(lines_total), 11);
    for (int i = 0; i < 20; i++) hard_piece(4);
    chk("level saturated", int'(level), 7);
    chk("lines after 91", int'(lines_total), 91);

    // game over and restart
    pulse_hard(); do_move(1); do_lock(0); do_spawn(1);
    chk("game_over", int'(game_over), 1);
    tick = 1; cyc(); tick = 0; cyc();
    chk("tick ignored in over", int'(down_req), 0);
    chk("still over", int'(game_over), 1);
    start = 1; cyc(); start = 0;
    chk("restart level", int'(level), 0);
    chk("restart lines", int'(lines_total), 0);
    chk("restart spawn_req", int'(spawn_req), 1);

    // reset in the middle of a lock handshake
    do_spawn(0);
    hard_piece(4);
    pulse_hard(); do_move(1);
    chk("lock_req before reset", int'(lock_req), 1);
    chk("lines before reset", int'(lines_total), 4);
    RESET = 1; cyc(); RESET = 0;
    chk("lock_req after reset", int'(lock_req), 0);
    chk("lines after reset", int'(lines_total), 0);
    chk("hard_drop after reset", int'(hard_drop), 0);
    start = 1; cyc(); start = 0;
    chk("start from idle after reset", int'(spawn_req), 1);

    // randomized play
    for (int i = 0; i < 6000; i++) begin
      RESET       = ($urandom_range(0, 599) == 0);
      start       = ($urandom_range(0, 29) == 0);
      tick        = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) soft_btn = ~soft_btn;
      hard_btn    = ($urandom_range(0, 39) == 0);
      spawn_done  = spawn_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      spawn_blocked = ($urandom_range(0, 7) == 0);
      down_done   = down_req ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0);
      down_blocked = ($urandom_range(0, 1) == 0);
      clear_done  = lock_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      clear_lines = 3'($urandom_range(0, 4));
      cyc();
    end
    RESET = 0; start = 0; tick = 0; hard_btn = 0;
    spawn_done = 0; down_done = 0; clear_done = 0;
    cyc();
    cmp_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fall_controller.md
# fall_controller

Sequences the life of each falling piece: spawn, gravity steps, lock delay, lock, line-clear accounting. Consumes the gravity tick from the level-speed clock divider and drives that divider's `drop`, `hard_drop` and `level` inputs. Issues move, lock and spawn requests to the board logic over req/done handshakes. Tracks cleared lines and derives the level from them.

## Interface
- `LOCK_DELAY`, default 25000000: cycles a grounded piece may rest before forced lock; 0.5 s at 50 MHz.
- `LINES_PER_LEVEL`, default 10: lines per level increment; must be ≥ 4.
- `MAX_LEVEL`, default 7: level saturation value.
- `CLK` in 1: system clock; the block's only clock.
- `RESET` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a game from IDLE or OVER.
- `tick` in 1: one-cycle gravity pulse from the divider.
- `soft_btn` in 1: soft-drop button, level-sensitive.
- `hard_btn` in 1: hard-drop button, one-cycle pulse.
- `spawn_req` out 1: request a new piece.
- `spawn_done` in 1: spawn completed.
- `spawn_blocked` in 1: qualified by `spawn_done`; 1 means no room to spawn.
- `down_req` out 1: request a one-row move down.
- `down_done` in 1: move evaluated.
- `down_blocked` in 1: qualified by `down_done`; 1 means the move was rejected.
- `lock_req` out 1: request to merge the piece into the board and clear lines.
- `clear_done` in 1: merge and clear finished.
- `clear_lines` in 3: qualified by `clear_done`; rows cleared, 0–4.
- `drop` out 1: soft-drop speed select to the divider.
- `hard_drop` out 1: hard-drop speed select to the divider.
- `level` out 3: current level to the divider.
- `lines_total` out 16: cumulative cleared lines, saturating.
- `game_over` out 1: high in OVER.

## Operation
- States: IDLE, SPAWN, FALL, MOVE, GROUND, LOCK, OVER.
- IDLE: `start` → SPAWN; also clears `lines_total`, `level` and the in-level line count.
- SPAWN: hold `spawn_req`. On `spawn_done`: blocked → OVER, otherwise → FALL. Clears the hard-mode flag.
- FALL: `tick` → MOVE.
- MOVE: hold `down_req` until `down_done`. Not blocked → FALL. Blocked with hard mode set → LOCK. Blocked from FALL → GROUND, lock counter cleared. Blocked from GROUND (a retry) → GROUND, counter kept.
- GROUND: the lock counter increments every cycle. `tick` → MOVE (retry after a sideways shift). Counter reaching `LOCK_DELAY-1` → LOCK; this takes priority over `tick` in the same cycle.
- LOCK: hold `lock_req` until `clear_done`. Add `clear_lines` to the line accounting, then → SPAWN.
- OVER: `game_over`=1. `start` → SPAWN, clearing as in IDLE.
- Hard mode:
  - `hard_btn` in FALL, MOVE or GROUND sets a flag held until the next SPAWN.
  - `hard_btn` in GROUND goes directly to LOCK.
  - `hard_btn` in IDLE, SPAWN, LOCK or OVER is ignored.
- `hard_drop` = hard flag.
- `drop` = `soft_btn` & ~hard flag & (state is FALL or MOVE).
- A `tick` arriving in any state other than FALL or GROUND is discarded; ticks are never queued.
- Line accounting:
  - `sum = in_level_cnt + clear_lines`.
  - If `sum ≥ LINES_PER_LEVEL`: `in_level_cnt = sum − LINES_PER_LEVEL` and `level` increments, saturating at `MAX_LEVEL`.
  - Otherwise `in_level_cnt = sum`.
  - `lines_total` adds `clear_lines` and saturates at 0xFFFF.
  - The in-level counter is 3–4 bits wide, sized from `LINES_PER_LEVEL`.

## Timing
- Reset values: state IDLE; every output 0 (`level`=0, `lines_total`=0, all reqs 0, `game_over`=0).
- All outputs are registered, or decoded from registered state and flags only. No input-to-output combinational path.
- Requests rise the cycle after entering their state. They fall the cycle after the matching done is sampled. A done seen with no request outstanding is ignored.
- `tick` in FALL at cycle n → `down_req` high at n+1.
- `down_done` with blocked at cycle m in hard mode → `lock_req` high at m+1.
- `level` and `lines_total` update the cycle after `clear_done`; `spawn_req` rises in that same cycle.
- The lock delay spans exactly `LOCK_DELAY` cycles from GROUND entry to LOCK entry when no tick intervenes.
- `RESET` mid-handshake drops all reqs the next cycle. The board side must tolerate a dropped req.

## Structure
- Package `fall_pkg`: state enum `fall_state_t`, default parameter constants, and the `lines_total` width.
- Sub-module `level_tracker` holds the in-level counter, level saturation and `lines_total` saturation. Its inputs are `clear_done`, `clear_lines` and a clear signal; its outputs are `level` and `lines_total`.
- The FSM and lock counter stay in `fall_controller`. Lock counter is 26 bits.

## Test plan
- Reset, then `start`; answer spawn with `spawn_done` and blocked=0 → FALL. Then `tick` → `down_req` one cycle later; done with blocked=0 → back in FALL, `drop`=0.
- Land with `LOCK_DELAY`=20 and no further ticks → `lock_req` exactly 20 cycles after GROUND entry. Then `clear_lines`=0 → SPAWN.
- `hard_btn` in FALL → `hard_drop`=1. Three unblocked moves then one blocked → `lock_req` with no lock delay; `hard_drop`=0 after the next spawn.
- Clears of 4, 4, 3 lines with `LINES_PER_LEVEL`=10 → `level` 0, 0, 1; `lines_total`=11; in-level count 1. Repeat to level 7 → holds at 7.
- `spawn_blocked`=1 → `game_over`=1 and ticks ignored. `start` → `level`=0, `lines_total`=0, `spawn_req`=1.
- `RESET` asserted while `lock_req` is high → all outputs 0 and state IDLE the next cycle.
